ppu_data_memory_responder: RTL and testbench

Multi-cycle data-memory responder for the PPU pipeline's MEM stage. It consumes the memory control group produced by the instruction decoder (MEM_Enable, MEM_RW, MEM_Size, MEM_SE) together with the effective address and store data. It performs big-endian byte, halfword and word accesses on an internal byte array after a configurable latency, and returns sign- or zero-extended load data with a one-cycle done pulse.

---
 rtl/ppu_data_memory_responder.sv | 196 +++++++++++++++++++
 tb/tb_ppu_data_memory_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_data_memory_responder.sv
// Data-memory responder for the PPU MEM stage: big-endian byte/half/word access to a local byte array.
// Latency: request accepted at edge k, done pulses in the cycle after edge k+LATENCY, IDLE after k+LATENCY+1.
// Backpressure: none; mem_enable is only sampled in IDLE, requests seen while busy or done are dropped.
module ppu_data_memory_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  input  logic        mem_se,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        misalign_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    rw_q, rw_d;
  logic [1:0]              size_q, size_d;
  logic                    se_q, se_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [31:0]             dout_q, dout_d;
  logic                    commit_store;

  // Backing store; deliberately never reset, contents undefined until written.
  logic [7:0]              mem_q [0:DEPTH-1];

  // Upper address bits are outside the array and intentionally ignored.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_WIDTH];

  // Byte lanes of the latched access, wrapping modulo the array size.
  logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_WIDTH'(1);
  assign a2 = addr_q + ADDR_WIDTH'(2);
  assign a3 = addr_q + ADDR_WIDTH'(3);

  logic                    misalign;
  logic [31:0]             load_val;

  // Alignment check on the latched request; reserved size is always rejected.
  always_comb begin
    misalign = 1'b0;
    case (size_q)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr_q[0];
      2'b10:   misalign = (addr_q[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  // Big-endian read of the addressed bytes with sign or zero extension.
  always_comb begin
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] hw;
    b0 = mem_q[a0];
    b1 = mem_q[a1];
    b2 = mem_q[a2];
    b3 = mem_q[a3];
    hw = {b0, b1};
    load_val = {b0, b1, b2, b3};
    case (size_q)
      2'b00:   load_val = se_q ? {{24{b0[7]}}, b0} : {24'h000000, b0};
      2'b01:   load_val = se_q ? {{16{hw[15]}}, hw} : {16'h0000, hw};
      default: load_val = {b0, b1, b2, b3};
    endcase
  end

  // Next-state, request latching and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    size_d       = size_q;
    se_d         = se_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    dout_d       = dout_q;
    commit_store = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_enable) begin
          state_d = S_ACCESS;
          cnt_d   = 4'(LATENCY - 1);
          rw_d    = mem_rw;
          size_d  = mem_size;
          se_d    = mem_se;
          addr_d  = address[ADDR_WIDTH-1:0];
          wdata_d = data_in;
          busy_d  = 1'b1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = misalign;
          if (!misalign) begin
            if (rw_q) begin
              commit_store = 1'b1;
            end else begin
              dout_d = load_val;
            end
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      se_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      se_q    <= se_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Store commit on the edge entering DONE; a reset in that cycle aborts it.
  always_ff @(posedge clk) begin
    if (!reset && commit_store) begin
      case (size_q)
        2'b00: begin
          mem_q[a0] <= wdata_q[7:0];
        end
        2'b01: begin
          mem_q[a0] <= wdata_q[15:8];
          mem_q[a1] <= wdata_q[7:0];
        end
        default: begin
          mem_q[a0] <= wdata_q[31:24];
          mem_q[a1] <= wdata_q[23:16];
          mem_q[a2] <= wdata_q[15:8];
          mem_q[a3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign data_out       = dout_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign misalign_error = err_q;

endmodule

// File: tb/tb_ppu_data_memory_responder.sv
// Bench for ppu_data_memory_responder: directed cases then random traffic against a byte-array model.
// Latency: each request is expected to show LATENCY busy cycles followed by a single done pulse.
// Backpressure: none; requests are issued only when the responder is idle, one extra strobe is poked mid-access.
module tb_ppu_data_memory_responder;

  localparam int AW  = 9;
  localparam int LAT = 2;
  localparam int SZ  = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_se;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;
  logic        misalign_error;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  model_mem [0:SZ-1];
  logic [31:0] exp_dout;

  ppu_data_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_enable     (mem_enable),
    .mem_rw         (mem_rw),
    .mem_size       (mem_size),
    .mem_se         (mem_se),
    .address        (address),
    .data_in        (data_in),
    .data_out       (data_out),
    .busy           (busy),
    .done           (done),
    .misalign_error (misalign_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || ((addr % nbytes(size)) != 0);
  endfunction

  // Reference read: assemble bytes most-significant first, then extend.
  function automatic logic [31:0] model_read(input logic [1:0] size, input bit se, input logic [31:0] addr);
    logic [31:0] v;
    int a;
    int n;
    a = int'(addr % SZ);
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(model_mem[(a + i) % SZ]);
    if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] dat);
    int a;
    int n;
    a = int'(addr % SZ);
    n = nbytes(size);
    for (int i = 0; i < n; i++) model_mem[(a + i) % SZ] = 8'(dat >> (8*(n-1-i)));
  endtask

  // Issues one request from a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_req(input string tag, input bit rw, input logic [1:0] size, input bit se,
                        input logic [31:0] addr, input logic [31:0] wdat, input bit poke);
    bit          bad;
    bit          seen;
    int          busy_cycles;
    int          extra_done;
    logic [31:0] exp_load;
    bad      = is_bad(size, addr);
    exp_load = 32'h0;
    if (!rw && !bad) exp_load = model_read(size, se, addr);
    mem_enable = 1'b1;
    mem_rw     = rw;
    mem_size   = size;
    mem_se     = se;
    address    = addr;
    data_in    = wdat;
    @(posedge clk);
    @(negedge clk);
    mem_enable = 1'b0;
    mem_rw     = 1'($urandom);
    mem_size   = 2'($urandom);
    mem_se     = 1'($urandom);
    address    = $urandom;
    data_in    = $urandom;
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        mem_enable = (poke && i == 0);
        @(negedge clk);
      end
    end
    mem_enable = 1'b0;
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    check({tag, "/busy_cycles"}, 32'(busy_cycles), 32'(LAT));
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "/misalign"}, 32'(misalign_error), 32'(bad));
    if (!bad) begin
      if (rw) model_write(size, addr, wdat);
      else    exp_dout = exp_load;
    end
    check({tag, "/data_out"}, data_out, exp_dout);
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
    check({tag, "/err_pulse"}, 32'(misalign_error), 32'd0);
    if (poke) begin
      extra_done = 0;
      for (int i = 0; i < LAT + 3; i++) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      check({tag, "/extra_done"}, 32'(extra_done), 32'd0);
    end
  endtask

  initial begin
    int          dones;
    logic [31:0] r;
    logic [31:0] a;
    logic [1:0]  sz;
    reset      = 1'b1;
    mem_enable = 1'b0;
    mem_rw     = 1'b0;
    mem_size   = 2'b00;
    mem_se     = 1'b0;
    address    = 32'h0;
    data_in    = 32'h0;
    exp_dout   = 32'h0;
    repeat (3) @(negedge clk);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/err", 32'(misalign_error), 32'd0);
    check("reset/data_out", data_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_req("st_w_010", 1, 2'b10, 0, 32'h010, 32'hA1B2C3D4, 0);
    do_req("ld_w_010", 0, 2'b10, 0, 32'h010, 32'h0, 0);
    check("ld_w_010/const", data_out, 32'hA1B2C3D4);
    do_req("ld_b_011_se", 0, 2'b00, 1, 32'h011, 32'h0, 0);
    check("ld_b_011_se/const", data_out, 32'hFFFFFFB2);
    do_req("ld_b_011_ze", 0, 2'b00, 0, 32'h011, 32'h0, 0);
    check("ld_b_011_ze/const", data_out, 32'h000000B2);
    do_req("ld_h_012_se", 0, 2'b01, 1, 32'h012, 32'h0, 0);
    check("ld_h_012_se/const", data_out, 32'hFFFFC3D4);
    do_req("ld_h_010_se", 0, 2'b01, 1, 32'h010, 32'h0, 0);
    check("ld_h_010_se/const", data_out, 32'hFFFFA1B2);
    do_req("st_b_013", 1, 2'b00, 0, 32'h013, 32'h000000EE, 0);
    do_req("ld_w_010b", 0, 2'b10, 0, 32'h010, 32'h0, 0);
    check("ld_w_010b/const", data_out, 32'hA1B2C3EE);

    do_req("st_w_013_bad", 1, 2'b10, 0, 32'h013, 32'h11111111, 0);
    do_req("ld_w_010c", 0, 2'b10, 0, 32'h010, 32'h0, 0);
    check("ld_w_010c/const", data_out, 32'hA1B2C3EE);
    do_req("ld_h_012_pre", 0, 2'b01, 0, 32'h012, 32'h0, 0);
    do_req("ld_sz3_bad", 0, 2'b11, 0, 32'h010, 32'h0, 0);
    do_req("ld_h_011_bad", 0, 2'b01, 1, 32'h011, 32'h0, 0);
    check("bad_loads/data_out_kept", data_out, 32'h0000C3EE);

    do_req("ld_poke", 0, 2'b10, 0, 32'h010, 32'h0, 1);
    do_req("st_w_200", 1, 2'b10, 0, 32'h00000200, 32'h55667788, 0);
    do_req("ld_w_000", 0, 2'b10, 0, 32'h000, 32'h0, 0);
    check("ld_w_000/const", data_out, 32'h55667788);

    // Reset one cycle into the access of a store must abort it.
    do_req("st_w_020", 1, 2'b10, 0, 32'h020, 32'h13572468, 0);
    mem_enable = 1'b1;
    mem_rw     = 1'b1;
    mem_size   = 2'b10;
    mem_se     = 1'b0;
    address    = 32'h020;
    data_in    = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    mem_enable = 1'b0;
    check("abort/busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/err", 32'(misalign_error), 32'd0);
    check("abort/data_out", data_out, 32'h0);
    reset    = 1'b0;
    exp_dout = 32'h0;
    dones    = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort/no_done", 32'(dones), 32'd0);
    do_req("ld_w_020", 0, 2'b10, 0, 32'h020, 32'h0, 0);
    check("ld_w_020/const", data_out, 32'h13572468);

    // Random traffic over a fully initialised window, with aliased upper bits.
    for (int i = 0; i < 16; i++) do_req("fill", 1, 2'b10, 0, 32'h100 + 32'(4*i), $urandom, 0);
    for (int i = 0; i < 60; i++) begin
      r  = $urandom;
      sz = 2'($urandom_range(0, 3));
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
      a  = (r & 32'hFFFF_FE00) | a;
      do_req("rand", 1'($urandom), sz, 1'($urandom), a, $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
